inst_mem_resp: RTL and testbench

INST_MEM_RESP -- requirements
Module: inst_mem_resp

---
 rtl/inst_mem_resp.sv | 119 +++++++++++
 tb/tb_inst_mem_resp.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_resp.sv
// inst_mem_resp: instruction memory responder for the fetch unit.
// Holds DEPTH 32-bit words that are loaded through the prog_* port.
// Serves one read request at a time through a valid/ready handshake.
// The response appears LATENCY+1 cycles after the request is accepted.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   req_valid/req_addr  read request carrying a byte address
//   req_ready           high only while idle
//   resp_valid/_inst/_err/resp_ready  response handshake
//   prog_we/_addr/_data memory load port, accepted in any state
//   err_cnt             saturating count of delivered error responses
module inst_mem_resp #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic [31:0]              req_addr,
    output logic                     req_ready,
    output logic                     resp_valid,
    output logic [31:0]              resp_inst,
    output logic                     resp_err,
    input  logic                     resp_ready,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [31:0]              prog_data,
    output logic [15:0]              err_cnt
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [3:0]  LAT4 = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_resp_valid;
    logic [31:0] r_resp_inst;
    logic        r_resp_err;
    logic [15:0] r_err_cnt;
    logic [31:0] r_mem [DEPTH];

    logic [AW-1:0] w_idx;
    logic          w_addr_err;

    assign w_idx      = r_addr[AW+1:2];
    assign w_addr_err = (r_addr[1:0] != 2'b00) || (r_addr[31:AW+2] != '0);

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_inst  = r_resp_inst;
    assign resp_err   = r_resp_err;
    assign err_cnt    = r_err_cnt;

    // Memory has no reset so that its contents survive rst.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    // The state becomes RESP on the edge where the counter reaches zero.
    // The response word is then captured on the first edge spent in RESP,
    // which gives the LATENCY+1 cycle spacing.  The read is registered, so a
    // write to the same word on the capture edge returns the old data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_inst  <= '0;
            r_resp_err   <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_cnt   <= LAT4;
                        r_state <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (!r_resp_valid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_addr_err;
                        r_resp_inst  <= w_addr_err ? '0 : r_mem[w_idx];
                    end else if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_inst  <= '0;
                        r_resp_err   <= 1'b0;
                        r_state      <= IDLE;
                        if (r_resp_err && (r_err_cnt != '1)) begin
                            r_err_cnt <= r_err_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_resp.sv
// Testbench for inst_mem_resp.
// Runs one instance with LATENCY=2 and one with LATENCY=0.
// Both instances share the clock, reset and program port.
module tb_inst_mem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data;

    logic        req_valid2, req_ready2, resp_valid2, resp_err2, resp_ready2;
    logic [31:0] req_addr2, resp_inst2;
    logic [15:0] err_cnt2;
    logic        req_valid0, req_ready0, resp_valid0, resp_err0, resp_ready0;
    logic [31:0] req_addr0, resp_inst0;
    logic [15:0] err_cnt0;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [32:0] q2[$];
    logic [32:0] q0[$];

    always #5 clk = ~clk;

    inst_mem_resp #(.DEPTH(64), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_addr(req_addr2), .req_ready(req_ready2),
        .resp_valid(resp_valid2), .resp_inst(resp_inst2), .resp_err(resp_err2),
        .resp_ready(resp_ready2),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .err_cnt(err_cnt2)
    );

    inst_mem_resp #(.DEPTH(64), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_addr(req_addr0), .req_ready(req_ready0),
        .resp_valid(resp_valid0), .resp_inst(resp_inst0), .resp_err(resp_err0),
        .resp_ready(resp_ready0),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .err_cnt(err_cnt0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop and compare on every response handshake.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (resp_valid2 && resp_ready2) begin
                if (q2.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_resp_lat2 got=%h required=none", {resp_err2, resp_inst2});
                end else begin
                    chk("resp_lat2", {31'd0, resp_err2, resp_inst2}, {31'd0, q2.pop_front()});
                end
            end
            if (!resp_valid2) chk("idle_outputs_zero_lat2", {31'd0, resp_err2, resp_inst2}, '0);
            if (resp_valid0 && resp_ready0) begin
                if (q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_resp_lat0 got=%h required=none", {resp_err0, resp_inst0});
                end else begin
                    chk("resp_lat0", {31'd0, resp_err0, resp_inst0}, {31'd0, q0.pop_front()});
                end
            end
            if (!resp_valid0) chk("idle_outputs_zero_lat0", {31'd0, resp_err0, resp_inst0}, '0);
        end
    end

    task automatic prog(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Issue a request and push its expected response.  Then check that
    // resp_valid rises exactly lat+1 edges after the acceptance edge.
    // With wr set, a program write is placed on the response capture edge.
    task automatic issue(input bit sel, input logic [31:0] a, input logic [31:0] ei,
                         input bit ee, input bit wr, input logic [5:0] wa,
                         input logic [31:0] wd);
        int unsigned lat;
        int unsigned n;
        bit found;
        lat = sel ? 0 : 2;
        n = 0;
        found = 1'b0;
        @(negedge clk);
        chk("req_ready_before_accept", {63'd0, sel ? req_ready0 : req_ready2}, 64'd1);
        if (sel) begin req_valid0 = 1'b1; req_addr0 = a; q0.push_back({ee, ei}); end
        else     begin req_valid2 = 1'b1; req_addr2 = a; q2.push_back({ee, ei}); end
        @(posedge clk);
        #1;
        req_valid0 = 1'b0; req_valid2 = 1'b0;
        while (n < 20 && !found) begin
            if (wr && n == lat) begin prog_we = 1'b1; prog_addr = wa; prog_data = wd; end
            @(posedge clk);
            #1;
            if (wr) prog_we = 1'b0;
            n++;
            if (sel ? resp_valid0 : resp_valid2) found = 1'b1;
        end
        chk("resp_valid_latency", {63'd0, found}, 64'd1);
        chk("resp_valid_cycles", 64'(n), 64'(lat + 1));
    endtask

    task automatic wait_idle(input bit sel);
        int unsigned n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < 30 && !(sel ? req_ready0 : req_ready2));
        chk("return_to_idle", {63'd0, sel ? req_ready0 : req_ready2}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        req_valid2 = 0; req_addr2 = '0; resp_ready2 = 1'b1;
        req_valid0 = 0; req_addr0 = '0; resp_ready0 = 1'b1;
        prog_we = 0; prog_addr = '0; prog_data = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #3;
        chk("rst_req_ready", {63'd0, req_ready2}, 64'd1);
        chk("rst_resp", {31'd0, resp_valid2, resp_err2, resp_inst2}, '0);
        chk("rst_err_cnt", {48'd0, err_cnt2}, '0);
        #19 rst = 1'b1;

        for (int i = 0; i < 4; i++) prog(6'(i), 32'h1111_0000 + 32'(i));

        // Four aligned reads, response 3 cycles after each acceptance.
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 32'(4 * i), 32'h1111_0000 + 32'(i), 1'b0, 1'b0, '0, '0);
            wait_idle(1'b0);
        end
        chk("err_cnt_after_good", {48'd0, err_cnt2}, 64'd0);

        // Misaligned and out-of-range requests.
        issue(1'b0, 32'h0000_0006, 32'h0, 1'b1, 1'b0, '0, '0);
        wait_idle(1'b0);
        issue(1'b0, 32'd256, 32'h0, 1'b1, 1'b0, '0, '0);
        wait_idle(1'b0);
        chk("err_cnt_after_errs", {48'd0, err_cnt2}, 64'd2);

        // Hold the response for 5 cycles while an ignored request is driven.
        resp_ready2 = 1'b0;
        issue(1'b0, 32'h0000_0008, 32'h1111_0002, 1'b0, 1'b0, '0, '0);
        held = resp_inst2;
        req_valid2 = 1'b1; req_addr2 = 32'h0000_0006;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", {63'd0, resp_valid2}, 64'd1);
            chk("stall_inst", {32'd0, resp_inst2}, {32'd0, held});
            chk("stall_err", {63'd0, resp_err2}, 64'd0);
            chk("stall_req_ready", {63'd0, req_ready2}, 64'd0);
        end
        #1 req_valid2 = 1'b0; resp_ready2 = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_release_idle", {63'd0, req_ready2}, 64'd1);
        chk("stall_release_valid", {63'd0, resp_valid2}, 64'd0);
        chk("err_cnt_ignored_req", {48'd0, err_cnt2}, 64'd2);

        // Zero-latency instance.
        issue(1'b1, 32'h0000_0008, 32'h1111_0002, 1'b0, 1'b0, '0, '0);
        wait_idle(1'b1);

        // Write on the capture edge returns old data; the next read sees new data.
        prog(6'd1, 32'h0000_0013);
        issue(1'b0, 32'h0000_0004, 32'h0000_0013, 1'b0, 1'b1, 6'd1, 32'hDEAD_BEEF);
        wait_idle(1'b0);
        issue(1'b0, 32'h0000_0004, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, '0);
        wait_idle(1'b0);

        // Reset in WAIT aborts the transaction without a response.
        @(negedge clk);
        req_valid2 = 1'b1; req_addr2 = 32'h0;
        @(posedge clk);
        #1 req_valid2 = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("abort_req_ready", {63'd0, req_ready2}, 64'd1);
        chk("abort_valid", {63'd0, resp_valid2}, 64'd0);
        chk("abort_err_cnt", {48'd0, err_cnt2}, 64'd0);
        #194 rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_no_resp", {63'd0, resp_valid2}, 64'd0);
        end
        chk("abort_idle", {63'd0, req_ready2}, 64'd1);
        chk("abort_err_cnt_after", {48'd0, err_cnt2}, 64'd0);
        issue(1'b0, 32'h0, 32'h1111_0000, 1'b0, 1'b0, '0, '0);
        wait_idle(1'b0);
        issue(1'b0, 32'h4, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, '0);
        wait_idle(1'b0);

        chk("scoreboard_empty_lat2", 64'(q2.size()), 64'd0);
        chk("scoreboard_empty_lat0", 64'(q0.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
